// File: rtl/ship_placer_if.sv
// ship_placer_if -- request and grid-access signals of ship_placer.
//
// Request side (environment -> placer):
//   start, cell_x, cell_y, ship_length, direction
// Grid side:
//   pointer_cell_x/y (placer -> grid) : grid address
//   status_pointed_cell (grid -> placer) : read data, one cycle after the pointer changes
//   we, new_value (placer -> grid) : write strobe and data
// Status (placer -> environment):
//   busy, ship_placed, rejected
//
// modport master : environment (requester plus grid memory)
// modport slave  : ship_placer
interface ship_placer_if;
  logic       start;
  logic [3:0] cell_x;
  logic [3:0] cell_y;
  logic [3:0] ship_length;
  logic       direction;
  logic [3:0] pointer_cell_x;
  logic [3:0] pointer_cell_y;
  logic [4:0] status_pointed_cell;
  logic       we;
  logic [4:0] new_value;
  logic       busy;
  logic       ship_placed;
  logic       rejected;

  modport master (
    output start, cell_x, cell_y, ship_length, direction, status_pointed_cell,
    input  pointer_cell_x, pointer_cell_y, we, new_value, busy, ship_placed, rejected
  );

  modport slave (
    input  start, cell_x, cell_y, ship_length, direction, status_pointed_cell,
    output pointer_cell_x, pointer_cell_y, we, new_value, busy, ship_placed, rejected
  );
endinterface

// File: rtl/ship_placer.sv
// ship_placer -- places a straight ship of ship_length cells on a square grid.
//
// A request is bounds-checked at the start edge; every cell is then read back
// from the grid (address cycle + evaluate cycle per cell). If all cells are
// free, each cell is written with CELL_PLAYER_OCC, one per cycle, in order,
// and ship_placed pulses. Any failure pulses rejected without writing.
//
// Ports:
//   clk_in : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   abort  : (only with SHIP_PLACER_ABORT_EN) cancel an operation, back to IDLE
//   bus    : ship_placer_if.slave -- request, grid access and status signals
//
// Optional feature macro: SHIP_PLACER_ABORT_EN
module ship_placer #(
  parameter int         GRID_SIZE       = 10,
  parameter logic [4:0] CELL_FREE       = 5'd0,
  parameter logic [4:0] CELL_PLAYER_OCC = 5'd1
) (
  input logic          clk_in,
  input logic          rst_n,
`ifdef SHIP_PLACER_ABORT_EN
  input logic          abort,
`endif
  ship_placer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_ADDR,
    CHK_EVAL,
    WRITE,
    DONE,
    REJECT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx;
  logic [3:0] idx_nxt;
  logic [3:0] ptr_x;
  logic [3:0] ptr_y;
  logic [3:0] ptr_x_nxt;
  logic [3:0] ptr_y_nxt;
  logic       latch_en;
  logic       wr;

  // Request captured at the start edge; the raw inputs are ignored afterwards.
  logic [3:0] org_x;
  logic [3:0] org_y;
  logic [3:0] len;
  logic       dir;

  // 5-bit arithmetic so origin + length cannot wrap.
  function automatic logic out_of_bounds(input logic [3:0] x, input logic [3:0] y,
                                         input logic [3:0] l, input logic d);
    logic [4:0] along;
    logic [4:0] other;
    logic [4:0] lim;
    lim   = 5'(GRID_SIZE);
    along = d ? {1'b0, y} : {1'b0, x};
    other = d ? {1'b0, x} : {1'b0, y};
    return (l == 4'd0) || ((along + {1'b0, l}) > lim) || (other >= lim);
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 4'd0;
      ptr_x <= 4'd0;
      ptr_y <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      ptr_x <= ptr_x_nxt;
      ptr_y <= ptr_y_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (latch_en) begin
      org_x <= bus.cell_x;
      org_y <= bus.cell_y;
      len   <= bus.ship_length;
      dir   <= bus.direction;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ptr_x_nxt = ptr_x;
    ptr_y_nxt = ptr_y;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          latch_en = 1'b1;
          // Bounds are judged on the live inputs so REJECT lands in cycle 1.
          if (out_of_bounds(bus.cell_x, bus.cell_y, bus.ship_length, bus.direction)) begin
            state_nxt = REJECT;
          end else begin
            state_nxt = CHK_ADDR;
            idx_nxt   = 4'd0;
            ptr_x_nxt = bus.cell_x;
            ptr_y_nxt = bus.cell_y;
          end
        end
      end
      CHK_ADDR: state_nxt = CHK_EVAL;
      CHK_EVAL: begin
        if (bus.status_pointed_cell != CELL_FREE) begin
          state_nxt = REJECT;
        end else if (idx == len - 4'd1) begin
          // All cells free: rewind the pointer to the origin for the write pass.
          state_nxt = WRITE;
          idx_nxt   = 4'd0;
          ptr_x_nxt = org_x;
          ptr_y_nxt = org_y;
        end else begin
          state_nxt = CHK_ADDR;
          idx_nxt   = idx + 4'd1;
          ptr_x_nxt = dir ? org_x : org_x + idx_nxt;
          ptr_y_nxt = dir ? org_y + idx_nxt : org_y;
        end
      end
      WRITE: begin
        if (idx == len - 4'd1) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 4'd1;
          ptr_x_nxt = dir ? org_x : org_x + idx_nxt;
          ptr_y_nxt = dir ? org_y + idx_nxt : org_y;
        end
      end
      DONE:    state_nxt = IDLE;
      REJECT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef SHIP_PLACER_ABORT_EN
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      idx_nxt   = idx;
      ptr_x_nxt = ptr_x;
      ptr_y_nxt = ptr_y;
      latch_en  = 1'b0;
    end
`endif
  end

  // Strobes decode straight from the state so reset clears them immediately.
  assign wr                 = (state == WRITE);
  assign bus.we             = wr;
  assign bus.new_value      = wr ? CELL_PLAYER_OCC : 5'd0;
  assign bus.pointer_cell_x = ptr_x;
  assign bus.pointer_cell_y = ptr_y;
  assign bus.busy           = (state != IDLE);
  assign bus.ship_placed    = (state == DONE);
  assign bus.rejected       = (state == REJECT);

endmodule

// File: tb/tb_ship_placer.sv
// tb_ship_placer -- directed bench for ship_placer with a 16x16 grid model.
// Cycle 0 is the edge that samples start; cycle c is the period after edge c-1,
// sampled on the falling edge.
module tb_ship_placer;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_n;
`ifdef SHIP_PLACER_ABORT_EN
  logic abort;
`endif

  ship_placer_if bus ();

  ship_placer #(
    .GRID_SIZE      (10),
    .CELL_FREE      (5'd0),
    .CELL_PLAYER_OCC(5'd1)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
`ifdef SHIP_PLACER_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  // Grid model: registered read, write on the edge that ends a we cycle.
  logic [4:0] grid [0:15][0:15];
  logic       clr;
  logic       poke;
  logic [3:0] poke_x;
  logic [3:0] poke_y;
  logic [4:0] poke_v;

  always @(posedge clk_in) begin
    if (clr) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          grid[i][j] <= 5'd0;
    end else if (poke) begin
      grid[poke_x][poke_y] <= poke_v;
    end else if (bus.we) begin
      grid[bus.pointer_cell_x][bus.pointer_cell_y] <= bus.new_value;
    end
    bus.status_pointed_cell <= grid[bus.pointer_cell_x][bus.pointer_cell_y];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic       lg_we   [64];
  logic       lg_busy [64];
  logic       lg_pl   [64];
  logic       lg_rj   [64];
  logic [3:0] lg_px   [64];
  logic [3:0] lg_py   [64];
  logic [4:0] lg_nv   [64];

  task automatic clear_grid();
    @(negedge clk_in); clr = 1'b1;
    @(negedge clk_in); clr = 1'b0;
  endtask

  task automatic poke_cell(input int x, input int y, input int v);
    @(negedge clk_in);
    poke = 1'b1; poke_x = 4'(x); poke_y = 4'(y); poke_v = 5'(v);
    @(negedge clk_in); poke = 1'b0;
  endtask

  // Drive a request through edge 0, then scramble the inputs to prove latching.
  task automatic start_op(input int x, input int y, input int l, input logic d);
    @(negedge clk_in);
    bus.cell_x = 4'(x); bus.cell_y = 4'(y); bus.ship_length = 4'(l);
    bus.direction = d; bus.start = 1'b1;
    @(posedge clk_in);
    #1;
    bus.start = 1'b0;
    bus.cell_x = 4'd15; bus.cell_y = 4'd15; bus.ship_length = 4'd15;
    bus.direction = ~d;
  endtask

  // Log cycles 1..n; start is re-pulsed during cycle 'rep' (0 = never).
  task automatic log_cycles(input int n, input int rep);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk_in);
      bus.start  = (c == rep);
      lg_we[c]   = bus.we;
      lg_busy[c] = bus.busy;
      lg_pl[c]   = bus.ship_placed;
      lg_rj[c]   = bus.rejected;
      lg_px[c]   = bus.pointer_cell_x;
      lg_py[c]   = bus.pointer_cell_y;
      lg_nv[c]   = bus.new_value;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_place(input string tag, input int x, input int y,
                             input int l, input logic d);
    int w0, w1, dn, ex, ey;
    w0 = 2 * l + 1;
    w1 = 3 * l;
    dn = 3 * l + 1;
    for (int c = 1; c <= dn + 1; c++) begin
      chk($sformatf("%s busy c%0d", tag, c), 32'(lg_busy[c]), 32'(c <= dn));
      chk($sformatf("%s we c%0d", tag, c), 32'(lg_we[c]), 32'(c >= w0 && c <= w1));
      chk($sformatf("%s new_value c%0d", tag, c), 32'(lg_nv[c]),
          (c >= w0 && c <= w1) ? 32'd1 : 32'd0);
      chk($sformatf("%s ship_placed c%0d", tag, c), 32'(lg_pl[c]), 32'(c == dn));
      chk($sformatf("%s rejected c%0d", tag, c), 32'(lg_rj[c]), 32'd0);
      if (c >= w0) begin
        // Pointer follows each write, then holds the last cell.
        ex = d ? x : x + ((c <= w1) ? c - w0 : l - 1);
        ey = d ? y + ((c <= w1) ? c - w0 : l - 1) : y;
        chk($sformatf("%s ptr_x c%0d", tag, c), 32'(lg_px[c]), 32'(ex));
        chk($sformatf("%s ptr_y c%0d", tag, c), 32'(lg_py[c]), 32'(ey));
      end
    end
    for (int k = 0; k < l; k++) begin
      ex = d ? x : x + k;
      ey = d ? y + k : y;
      chk($sformatf("%s grid(%0d,%0d)", tag, ex, ey), 32'(grid[ex][ey]), 32'd1);
    end
    ex = d ? x : x + l;
    ey = d ? y + l : y;
    chk($sformatf("%s grid beyond end", tag), 32'(grid[ex][ey]), 32'd0);
  endtask

  task automatic check_reject(input string tag, input int rc, input int n);
    for (int c = 1; c <= n; c++) begin
      chk($sformatf("%s busy c%0d", tag, c), 32'(lg_busy[c]), 32'(c <= rc));
      chk($sformatf("%s rejected c%0d", tag, c), 32'(lg_rj[c]), 32'(c == rc));
      chk($sformatf("%s we c%0d", tag, c), 32'(lg_we[c]), 32'd0);
      chk($sformatf("%s ship_placed c%0d", tag, c), 32'(lg_pl[c]), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; poke = 1'b0; poke_x = 4'd0; poke_y = 4'd0; poke_v = 5'd0;
    bus.start = 1'b0; bus.cell_x = 4'd0; bus.cell_y = 4'd0;
    bus.ship_length = 4'd0; bus.direction = 1'b0;
`ifdef SHIP_PLACER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk_in);
    chk("reset we", 32'(bus.we), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset ptr_x", 32'(bus.pointer_cell_x), 32'd0);
    chk("reset ptr_y", 32'(bus.pointer_cell_y), 32'd0);
    chk("reset new_value", 32'(bus.new_value), 32'd0);
    chk("reset ship_placed", 32'(bus.ship_placed), 32'd0);
    chk("reset rejected", 32'(bus.rejected), 32'd0);
    rst_n = 1'b1;

    // Horizontal placement on a free grid
    clear_grid();
    start_op(2, 4, 3, 1'b0);
    log_cycles(11, 0);
    check_place("h3", 2, 4, 3, 1'b0);

    // Vertical run off the bottom edge
    clear_grid();
    start_op(9, 7, 4, 1'b1);
    log_cycles(3, 0);
    check_reject("oob_v", 1, 3);

    // Exact fit against the right edge (6+4 == 10)
    clear_grid();
    start_op(6, 0, 4, 1'b0);
    log_cycles(14, 0);
    check_place("fit", 6, 0, 4, 1'b0);

    // Vertical placement, exact fit to the bottom edge (3+7 == 10)
    clear_grid();
    start_op(5, 3, 7, 1'b1);
    log_cycles(23, 0);
    check_place("v7", 5, 3, 7, 1'b1);

    // Zero length
    start_op(0, 0, 0, 1'b0);
    log_cycles(3, 0);
    check_reject("len0", 1, 3);

    // Cross coordinate off the grid
    start_op(3, 10, 2, 1'b0);
    log_cycles(3, 0);
    check_reject("cross", 1, 3);

    // Occupied second cell
    clear_grid();
    poke_cell(1, 0, 2);
    start_op(0, 0, 3, 1'b0);
    log_cycles(7, 0);
    check_reject("occ", 5, 7);
    chk("occ grid(0,0)", 32'(grid[0][0]), 32'd0);
    chk("occ grid(1,0)", 32'(grid[1][0]), 32'd2);
    chk("occ grid(2,0)", 32'(grid[2][0]), 32'd0);

    // start re-pulsed while busy must be ignored
    clear_grid();
    start_op(2, 4, 3, 1'b0);
    log_cycles(11, 3);
    check_place("repulse", 2, 4, 3, 1'b0);
    chk("repulse grid(15,15)", 32'(grid[15][15]), 32'd0);

    // Reset in the middle of the write pass
    clear_grid();
    start_op(2, 4, 3, 1'b0);
    log_cycles(7, 0);
    chk("rst we c7", 32'(lg_we[7]), 32'd1);
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    chk("rst we now", 32'(bus.we), 32'd0);
    chk("rst busy now", 32'(bus.busy), 32'd0);
    chk("rst new_value now", 32'(bus.new_value), 32'd0);
    chk("rst ptr_x now", 32'(bus.pointer_cell_x), 32'd0);
    chk("rst ptr_y now", 32'(bus.pointer_cell_y), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    chk("rst grid(2,4)", 32'(grid[2][4]), 32'd1);
    chk("rst grid(3,4)", 32'(grid[3][4]), 32'd0);
    chk("rst grid(4,4)", 32'(grid[4][4]), 32'd0);
    clear_grid();
    start_op(2, 4, 3, 1'b0);
    log_cycles(11, 0);
    check_place("after_rst", 2, 4, 3, 1'b0);

`ifdef SHIP_PLACER_ABORT_EN
    // Abort during the check pass
    clear_grid();
    start_op(2, 4, 3, 1'b0);
    log_cycles(3, 0);
    @(negedge clk_in);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    chk("abort busy c5", 32'(bus.busy), 32'd0);
    chk("abort we c5", 32'(bus.we), 32'd0);
    log_cycles(8, 0);
    check_reject("abort", 0, 8);
    chk("abort grid(2,4)", 32'(grid[2][4]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ship_placer.md
SHIP_PLACER -- requirements
Module: ship_placer

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 10, cells per grid row and column (legal range 1..15).
REQ-002 SHALL have parameter CELL_FREE, default 5'd0, the status code of an empty cell.
REQ-003 SHALL have parameter CELL_PLAYER_OCC, default 5'd1, the status code written for a placed ship cell.
REQ-004 SHALL have port clk_in, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit, placement request, sampled only in IDLE.
REQ-007 SHALL have ports cell_x and cell_y, input, 4 bits each, the ship origin cell.
REQ-008 SHALL have port ship_length, input, 4 bits, the number of ship cells.
REQ-009 SHALL have port direction, input, 1 bit: 0 = horizontal (x increments), 1 = vertical (y increments).
REQ-010 SHALL have ports pointer_cell_x and pointer_cell_y, output, 4 bits each, the grid address.
REQ-011 SHALL have port status_pointed_cell, input, 5 bits, the grid read data, valid one cycle after the pointer changes.
REQ-012 SHALL have port we, output, 1 bit, the grid write strobe.
REQ-013 SHALL have port new_value, output, 5 bits, the grid write data.
REQ-014 SHALL have port busy, output, 1 bit, high in every non-IDLE state.
REQ-015 SHALL have port ship_placed, output, 1 bit, a one-cycle success pulse.
REQ-016 SHALL have port rejected, output, 1 bit, a one-cycle failure pulse.

Function
REQ-017 SHALL implement an FSM with states IDLE, CHK_ADDR, CHK_EVAL, WRITE, DONE and REJECT.
REQ-018 On start=1 in IDLE, SHALL latch cell_x, cell_y, ship_length and direction; the latched values SHALL be used for the rest of the operation.
REQ-019 Bounds check, in 5-bit arithmetic: if ship_length==0, or (origin coordinate along direction)+ship_length>GRID_SIZE, or the other coordinate >= GRID_SIZE, SHALL enter REJECT in cycle 1 (cycle 0 = start sample edge).
REQ-020 Otherwise SHALL enter CHK_ADDR in cycle 1.
REQ-021 Per cell k (0..L-1): CHK_ADDR drives the pointer to the origin plus k along direction; the next cycle, CHK_EVAL samples status_pointed_cell; each cell check SHALL take 2 cycles.
REQ-022 If any sampled status != CELL_FREE, SHALL go to REJECT on the next cycle with no write issued.
REQ-023 After all L cells pass the check, SHALL spend L WRITE cycles, one per cell in the same order, with we=1, new_value=CELL_PLAYER_OCC and the pointer on that cell.
REQ-024 For a successful placement of length L, the write cycles SHALL be 2L+1..3L.
REQ-025 DONE SHALL occur in cycle 3L+1 with ship_placed=1 for exactly one cycle, followed by IDLE.
REQ-026 REJECT SHALL last one cycle with rejected=1, followed by IDLE.
REQ-027 we SHALL be 0 outside WRITE; new_value SHALL be 0 outside WRITE.
REQ-028 start asserted while busy SHALL be ignored and not queued.
REQ-029 The pointer SHALL hold its last value in IDLE, DONE and REJECT.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE; pointer 0,0; we, new_value, busy, ship_placed and rejected all 0.
REQ-031 Reset during WRITE SHALL stop further writes; cells already written remain written.

Configuration
REQ-032 Macro SHIP_PLACER_ABORT_EN: when defined, SHALL add input port abort (1 bit); abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with we=0 from that edge and no ship_placed or rejected pulse.
REQ-033 When SHIP_PLACER_ABORT_EN is not defined, the abort port SHALL be absent and an operation, once started, SHALL always end in DONE or REJECT.

Verification
REQ-034 All free, start with (2,4), L=3, dir=0: writes to (2,4),(3,4),(4,4) in cycles 7,8,9 with new_value=1; ship_placed in cycle 10; busy over cycles 1..10.
REQ-035 Start with (9,7), L=4, dir=1 (7+4>10): rejected in cycle 1; we never asserted.
REQ-036 Start with (0,0), L=3, dir=0, cell (1,0)=5'd2: rejected in cycle 5; zero write cycles.
REQ-037 start re-pulsed in cycle 3 of a valid operation: it is ignored and the first operation completes unchanged.
REQ-038 rst_n low in cycle 8 of the REQ-034 case: outputs 0 at once; only (2,4) written; next start accepted normally.
REQ-039 With SHIP_PLACER_ABORT_EN defined, abort in cycle 4: IDLE in cycle 5, no write, no pulse.
